noc_output_arbiter: RTL

- Shares one router output port between PORTS input requesters. Uses round-robin arbitration with wormhole locking: a packet holds the port from its head flit through its tail flit.
- Drives the output through a one-entry registered stage with valid/ready handshake.
- One instance per output port sits between the input buffers and the link in front of noc_router.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/noc_output_arbiter_if.sv | 27 ++
 rtl/noc_rr_arbiter.sv | 36 +++
 rtl/noc_output_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC definitions.
//   - flit_type_e   : 2-bit flit type carried in the top two bits of every flit
//   - FLIT_TYPE_MSB/LSB : offsets of the type field below FLIT_WIDTH
//   - port_id_w()   : width of a port index for a given port count
//   - lock_state_e  : output-port lock state used by noc_output_arbiter
package noc_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Type field lives at [FLIT_WIDTH-FLIT_TYPE_MSB : FLIT_WIDTH-FLIT_TYPE_LSB].
    localparam int unsigned FLIT_TYPE_MSB = 1;
    localparam int unsigned FLIT_TYPE_LSB = 2;

    // Keep at least one bit so a single-port instance still has a legal index.
    function automatic int unsigned port_id_w(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    typedef enum logic [0:0] {
        StUnlocked = 1'b0,
        StLocked   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if: request side and output side handshake of one router output port.
//   req_flit/req_valid/req_ready : per-input candidate flits and accept strobes
//   out_flit/out_valid/out_ready : registered output towards the link
// Modports: master = upstream/downstream environment, slave = the arbiter.
interface noc_output_arbiter_if #(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned PORTS      = 5
) ();

    logic [PORTS-1:0][FLIT_WIDTH-1:0] req_flit;
    logic [PORTS-1:0]                 req_valid;
    logic [PORTS-1:0]                 req_ready;
    logic [FLIT_WIDTH-1:0]            out_flit;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output req_flit, req_valid, out_ready,
        input  req_ready, out_flit, out_valid
    );

    modport slave (
        input  req_flit, req_valid, out_ready,
        output req_ready, out_flit, out_valid
    );

endinterface

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: combinational round-robin pick.
//   req_i       : request vector
//   ptr_i       : highest-priority index this cycle
//   gnt_o       : one-hot grant (first request at or after ptr_i, wrapping)
//   gnt_idx_o   : index of the granted request (0 when none)
//   gnt_valid_o : any request granted
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned PORTS = 5
) (
    input  logic [PORTS-1:0]              req_i,
    input  logic [port_id_w(PORTS)-1:0]   ptr_i,
    output logic [PORTS-1:0]              gnt_o,
    output logic [port_id_w(PORTS)-1:0]   gnt_idx_o,
    output logic                          gnt_valid_o
);

    localparam int unsigned IdW = port_id_w(PORTS);

    always_comb begin
        int unsigned idx;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int unsigned off = 0; off < PORTS; off++) begin
            idx = (int'(ptr_i) + off) % PORTS;
            if (!gnt_valid_o && req_i[IdW'(idx)]) begin
                gnt_valid_o       = 1'b1;
                gnt_o[IdW'(idx)]  = 1'b1;
                gnt_idx_o         = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: shares one router output port between PORTS inputs.
// Round-robin among HEAD/SINGLE flits; a HEAD locks the port to its input until
// the TAIL transfers. The chosen flit goes through a one-entry registered stage.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/output handshake (slave modport)
//   lock_active : a packet owns the port
//   lock_owner  : owning input (0 when unlocked)
//   proto_err   : sticky, orphan BODY/TAIL while unlocked or HEAD/SINGLE from owner
//   stall_err   : sticky, lock held TIMEOUT cycles without a transfer
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned PORTS      = 5,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    noc_output_arbiter_if.slave         bus,
    output logic                        lock_active,
    output logic [port_id_w(PORTS)-1:0] lock_owner,
    output logic                        proto_err,
    output logic                        stall_err
);

    localparam int unsigned IdW  = port_id_w(PORTS);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    lock_state_e           state_q, state_d;
    logic [IdW-1:0]        lock_owner_q, lock_owner_d;
    logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  out_valid_q, out_valid_d;
    logic                  proto_err_q, proto_err_d;
    logic                  stall_err_q, stall_err_d;
    logic [CntW-1:0]       idle_cnt_q, idle_cnt_d;

    flit_type_e            req_type [PORTS];
    logic [PORTS-1:0]      eligible, orphan;
    logic [PORTS-1:0]      arb_gnt, req_ready;
    logic [IdW-1:0]        arb_idx, xfer_idx;
    logic                  arb_valid, load, xfer;
    flit_type_e            xfer_type;

    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            req_type[i] = flit_type_e'(
                bus.req_flit[i][FLIT_WIDTH-FLIT_TYPE_MSB:FLIT_WIDTH-FLIT_TYPE_LSB]);
            eligible[i] = bus.req_valid[i] &&
                          (req_type[i] == FLIT_HEAD || req_type[i] == FLIT_SINGLE);
            orphan[i]   = bus.req_valid[i] &&
                          (req_type[i] == FLIT_BODY || req_type[i] == FLIT_TAIL);
        end
    end

    noc_rr_arbiter #(
        .PORTS(PORTS)
    ) u_rr_arbiter (
        .req_i      (eligible),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (arb_gnt),
        .gnt_idx_o  (arb_idx),
        .gnt_valid_o(arb_valid)
    );

    always_comb begin
        load      = !out_valid_q || bus.out_ready;
        req_ready = '0;
        xfer_idx  = arb_idx;
        if (!rst && load) begin
            if (state_q == StLocked) begin
                req_ready[lock_owner_q] = 1'b1;
                xfer_idx                = lock_owner_q;
            end else if (arb_valid) begin
                req_ready = arb_gnt;
            end
        end
        xfer      = |(bus.req_valid & req_ready);
        xfer_type = req_type[xfer_idx];

        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        rr_ptr_d     = rr_ptr_q;
        out_flit_d   = out_flit_q;
        out_valid_d  = out_valid_q;
        proto_err_d  = proto_err_q;
        stall_err_d  = stall_err_q;
        idle_cnt_d   = idle_cnt_q;

        // out_flit is held when nothing new is loaded; only valid drops.
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_flit_d = bus.req_flit[xfer_idx];
            end
        end

        unique case (state_q)
            StUnlocked: begin
                idle_cnt_d = '0;
                if (|orphan) begin
                    proto_err_d = 1'b1;
                end
                if (xfer) begin
                    rr_ptr_d = (xfer_idx == IdW'(PORTS - 1)) ? '0 : xfer_idx + IdW'(1);
                    if (xfer_type == FLIT_HEAD) begin
                        state_d      = StLocked;
                        lock_owner_d = xfer_idx;
                    end
                end
            end
            StLocked: begin
                if (xfer) begin
                    idle_cnt_d = '0;
                    if (xfer_type == FLIT_TAIL) begin
                        state_d      = StUnlocked;
                        lock_owner_d = '0;
                    end else if (xfer_type == FLIT_HEAD || xfer_type == FLIT_SINGLE) begin
                        // Forwarded as data; lock is kept.
                        proto_err_d = 1'b1;
                    end
                end else if (idle_cnt_q != CntW'(TIMEOUT)) begin
                    idle_cnt_d = idle_cnt_q + CntW'(1);
                end
                if (idle_cnt_d == CntW'(TIMEOUT)) begin
                    stall_err_d = 1'b1;
                end
            end
            default: state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StUnlocked;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
            out_flit_q   <= '0;
            out_valid_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            stall_err_q  <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            proto_err_q  <= proto_err_d;
            stall_err_q  <= stall_err_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_flit  = out_flit_q;
    assign bus.out_valid = out_valid_q;
    assign lock_active   = (state_q == StLocked);
    assign lock_owner    = lock_owner_q;
    assign proto_err     = proto_err_q;
    assign stall_err     = stall_err_q;

endmodule
